// File: rtl/fpu_issue_pkg.sv
// Shared types and constants for the FPU issue/sequencing stage: FSM encoding,
// canonical NaN, default widths and the opcode map shared with the decoder.
package fpu_issue_pkg;

  localparam int OP_W_DEF = 5;
  localparam int RD_W_DEF = 5;

  localparam logic [31:0] FP_CANON_NAN = 32'h7FC0_0000;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_START = 3'd1,
    ST_WAIT  = 3'd2,
    ST_DONE  = 3'd3,
    ST_DRAIN = 3'd4
  } state_e;

  localparam logic [OP_W_DEF-1:0] FPU_OP_ADD     = 5'd0;
  localparam logic [OP_W_DEF-1:0] FPU_OP_SUB     = 5'd1;
  localparam logic [OP_W_DEF-1:0] FPU_OP_MUL     = 5'd2;
  localparam logic [OP_W_DEF-1:0] FPU_OP_DIV     = 5'd3;
  localparam logic [OP_W_DEF-1:0] FPU_OP_SQRT    = 5'd4;
  localparam logic [OP_W_DEF-1:0] FPU_OP_MIN     = 5'd5;
  localparam logic [OP_W_DEF-1:0] FPU_OP_MAX     = 5'd6;
  localparam logic [OP_W_DEF-1:0] FPU_OP_CVT_I2F = 5'd7;
  localparam logic [OP_W_DEF-1:0] FPU_OP_CVT_F2I = 5'd8;

  // States in which the core is busy and the watchdog is counting.
  function automatic logic is_watched(input state_e s);
    return (s == ST_WAIT) || (s == ST_DRAIN);
  endfunction

endpackage

// File: rtl/fpu_watchdog.sv
// Cycle counter for the WAIT/DRAIN states; expired is high during the LIMIT-th
// consecutive watched cycle. Instantiated only when FPU_TIMEOUT_EN is defined.
module fpu_watchdog #(
  parameter int LIMIT = 64
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  input  logic active,
  output logic expired
);

  localparam int CNT_W = $clog2(LIMIT + 1);

  logic [CNT_W-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (restart) begin
      cnt_d = '0;
    end else if (active) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign expired = active && (cnt_q == CNT_W'(LIMIT - 1));

endmodule

// File: rtl/fpu_issue_ctrl.sv
// Issue/sequencing stage in front of the FPU core: one op in flight, start pulse,
// result capture and valid/ready hand-off. Optional watchdog: define FPU_TIMEOUT_EN.
module fpu_issue_ctrl
  import fpu_issue_pkg::*;
#(
  parameter int XLEN        = 32,
  parameter int OP_W        = OP_W_DEF,
  parameter int RD_W        = RD_W_DEF,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic            in_Clk,
  input  logic            in_Rst,
  input  logic            in_valid,
  output logic            out_ready,
  input  logic [OP_W-1:0] in_fpu_op,
  input  logic [XLEN-1:0] in_rs1,
  input  logic [XLEN-1:0] in_rs2,
  input  logic [XLEN-1:0] in_int,
  input  logic [RD_W-1:0] in_rd,
  input  logic            in_flush,
  output logic            out_start,
  output logic [OP_W-1:0] out_fpu_op,
  output logic [XLEN-1:0] out_rs1,
  output logic [XLEN-1:0] out_rs2,
  output logic [XLEN-1:0] out_int,
  input  logic [XLEN-1:0] in_fpu_data,
  input  logic            in_fpu_stall,
  output logic            out_valid,
  input  logic            in_ready,
  output logic [XLEN-1:0] out_data,
  output logic [RD_W-1:0] out_rd,
  output logic            out_pipe_stall,
  output logic            out_timeout
);

  state_e          state_q, state_d;
  logic [OP_W-1:0] op_q, op_d;
  logic [XLEN-1:0] rs1_q, rs1_d;
  logic [XLEN-1:0] rs2_q, rs2_d;
  logic [XLEN-1:0] int_q, int_d;
  logic [RD_W-1:0] rd_q, rd_d;
  logic [XLEN-1:0] data_q, data_d;
  logic            wd_expired;

  // NOTE: every variable is given its default first, so no branch can leave one
  // unassigned and infer a latch.
  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    rs1_d   = rs1_q;
    rs2_d   = rs2_q;
    int_d   = int_q;
    rd_d    = rd_q;
    data_d  = data_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid && !in_flush) begin
          op_d    = in_fpu_op;
          rs1_d   = in_rs1;
          rs2_d   = in_rs2;
          int_d   = in_int;
          rd_d    = in_rd;
          state_d = ST_START;
        end
      end
      ST_START: state_d = in_flush ? ST_DRAIN : ST_WAIT;
      ST_WAIT: begin
        // A flush beats a result arriving in the same cycle.
        if (in_flush) begin
          state_d = ST_DRAIN;
        end else if (!in_fpu_stall) begin
          data_d  = in_fpu_data;
          state_d = ST_DONE;
        end else if (wd_expired) begin
          data_d  = XLEN'(FP_CANON_NAN);
          state_d = ST_DONE;
        end
      end
      ST_DONE: begin
        if (in_flush || in_ready) begin
          state_d = ST_IDLE;
        end
      end
      ST_DRAIN: begin
        // The core cannot abort; wait for it to finish before taking new work.
        if (!in_fpu_stall || wd_expired) begin
          state_d = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples its pre-edge value and they all update together.
  always_ff @(posedge in_Clk) begin
    if (in_Rst) begin
      state_q <= ST_IDLE;
      op_q    <= '0;
      rs1_q   <= '0;
      rs2_q   <= '0;
      int_q   <= '0;
      rd_q    <= '0;
      data_q  <= '0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      rs1_q   <= rs1_d;
      rs2_q   <= rs2_d;
      int_q   <= int_d;
      rd_q    <= rd_d;
      data_q  <= data_d;
    end
  end

`ifdef FPU_TIMEOUT_EN
  logic timeout_q, timeout_d;
  logic wd_restart;

  assign wd_restart = is_watched(state_d) && (state_d != state_q);

  fpu_watchdog #(
    .LIMIT(TIMEOUT_CYC)
  ) u_watchdog (
    .clk    (in_Clk),
    .rst    (in_Rst),
    .restart(wd_restart),
    .active (is_watched(state_q)),
    .expired(wd_expired)
  );

  // Fires only when expiry actually drove the transition; held through DONE.
  always_comb begin
    timeout_d = 1'b0;
    if (wd_expired && in_fpu_stall && (state_q == ST_DRAIN || !in_flush)) begin
      timeout_d = 1'b1;
    end else if (state_q == ST_DONE && state_d == ST_DONE) begin
      timeout_d = timeout_q;
    end
  end

  always_ff @(posedge in_Clk) begin
    if (in_Rst) begin
      timeout_q <= 1'b0;
    end else begin
      timeout_q <= timeout_d;
    end
  end

  assign out_timeout = timeout_q;
`else
  assign wd_expired  = 1'b0;
  assign out_timeout = 1'b0;
`endif

  assign out_ready      = (state_q == ST_IDLE);
  assign out_start      = (state_q == ST_START);
  assign out_valid      = (state_q == ST_DONE);
  assign out_pipe_stall = (state_q != ST_IDLE) && !((state_q == ST_DONE) && in_ready);
  assign out_fpu_op     = op_q;
  assign out_rs1        = rs1_q;
  assign out_rs2        = rs2_q;
  assign out_int        = int_q;
  assign out_data       = data_q;
  assign out_rd         = rd_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Self-checking bench for fpu_issue_ctrl: vector table, multi-cycle corner
// sequences and a randomized run against a transaction-level scoreboard.
module tb_fpu_issue_ctrl;
  import fpu_issue_pkg::*;

  localparam int XLEN   = 32;
  localparam int OP_W   = 5;
  localparam int RD_W   = 5;
  localparam int TO_CYC = 8;

  logic            in_Clk = 1'b0;
  logic            in_Rst;
  logic            in_valid;
  logic            out_ready;
  logic [OP_W-1:0] in_fpu_op;
  logic [XLEN-1:0] in_rs1, in_rs2, in_int;
  logic [RD_W-1:0] in_rd;
  logic            in_flush;
  logic            out_start;
  logic [OP_W-1:0] out_fpu_op;
  logic [XLEN-1:0] out_rs1, out_rs2, out_int;
  logic [XLEN-1:0] in_fpu_data;
  logic            in_fpu_stall;
  logic            out_valid;
  logic            in_ready;
  logic [XLEN-1:0] out_data;
  logic [RD_W-1:0] out_rd;
  logic            out_pipe_stall;
  logic            out_timeout;

  fpu_issue_ctrl #(
    .XLEN(XLEN), .OP_W(OP_W), .RD_W(RD_W), .TIMEOUT_CYC(TO_CYC)
  ) dut (
    .in_Clk(in_Clk), .in_Rst(in_Rst), .in_valid(in_valid), .out_ready(out_ready),
    .in_fpu_op(in_fpu_op), .in_rs1(in_rs1), .in_rs2(in_rs2), .in_int(in_int),
    .in_rd(in_rd), .in_flush(in_flush), .out_start(out_start),
    .out_fpu_op(out_fpu_op), .out_rs1(out_rs1), .out_rs2(out_rs2), .out_int(out_int),
    .in_fpu_data(in_fpu_data), .in_fpu_stall(in_fpu_stall), .out_valid(out_valid),
    .in_ready(in_ready), .out_data(out_data), .out_rd(out_rd),
    .out_pipe_stall(out_pipe_stall), .out_timeout(out_timeout)
  );

  always #5 in_Clk = ~in_Clk;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Snapshot of DUT outputs taken mid-cycle.
  logic            s_ready, s_start, s_valid, s_pstall, s_timeout;
  logic [OP_W-1:0] s_op;
  logic [XLEN-1:0] s_rs1, s_rs2, s_int, s_data;
  logic [RD_W-1:0] s_rd;

  // Core model: stalls core_lat cycles after a start, or forever while stuck.
  int          core_busy     = 0;
  int          core_lat      = 0;
  bit          core_stuck    = 0;
  bit          core_override = 0;
  logic [31:0] override_val  = '0;
  logic [31:0] core_res      = '0;

  function automatic logic [31:0] core_fn(input logic [4:0] op, input logic [31:0] a,
                                          input logic [31:0] b, input logic [31:0] c);
    return (a ^ {b[15:0], b[31:16]}) + c + {27'd0, op};
  endfunction

  task automatic cycle();
    @(negedge in_Clk);
    s_ready = out_ready;  s_start = out_start;   s_valid = out_valid;
    s_pstall = out_pipe_stall; s_timeout = out_timeout;
    s_op = out_fpu_op; s_rs1 = out_rs1; s_rs2 = out_rs2; s_int = out_int;
    s_data = out_data; s_rd = out_rd;
    @(posedge in_Clk);
    if (in_Rst) begin
      core_busy = 0;
    end else if (s_start === 1'b1) begin
      check("core_idle_at_start", core_busy, 0);
      core_busy = core_lat;
      core_res  = core_override ? override_val : core_fn(s_op, s_rs1, s_rs2, s_int);
    end else if (core_busy > 0) begin
      core_busy--;
    end
    #1;
    in_fpu_stall = core_stuck || (core_busy > 0);
    in_fpu_data  = core_res;
  endtask

  typedef struct {
    logic [4:0]  op;
    logic [31:0] rs1, rs2, iv, res;
    logic [4:0]  rd;
    int          lat, dly, exp_valid_cyc;
    logic [31:0] exp_data;
  } vec_t;

  vec_t vecs[5];

  task automatic drive_op(input logic [4:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] c, input logic [4:0] rd);
    in_fpu_op = op; in_rs1 = a; in_rs2 = b; in_int = c; in_rd = rd;
  endtask

  task automatic run_op(input vec_t v);
    int start_c, valid_c, n_st;
    logic [4:0] st_op;
    logic [31:0] st_rs1, st_rs2, st_int;
    core_override = 1; override_val = v.res; core_lat = v.lat;
    in_flush = 0; in_ready = 0;
    drive_op(v.op, v.rs1, v.rs2, v.iv, v.rd);
    in_valid = 1;
    cycle();
    check("op_accept_ready", s_ready, 1);
    in_valid = 0;
    drive_op(~v.op, ~v.rs1, ~v.rs2, ~v.iv, ~v.rd);
    start_c = -1; valid_c = -1; n_st = 0;
    st_op = '0; st_rs1 = '0; st_rs2 = '0; st_int = '0;
    for (int c = 1; c <= 40 && valid_c < 0; c++) begin
      cycle();
      check("op_pipe_stall_busy", s_pstall, 1);
      if (s_start) begin
        n_st++;
        if (start_c < 0) begin
          start_c = c; st_op = s_op; st_rs1 = s_rs1; st_rs2 = s_rs2; st_int = s_int;
        end
      end
      if (s_valid) valid_c = c;
    end
    check("op_start_cycle", start_c, 1);
    check("op_start_count", n_st, 1);
    check("op_latched_op", st_op, v.op);
    check("op_latched_rs1", st_rs1, v.rs1);
    check("op_latched_rs2", st_rs2, v.rs2);
    check("op_latched_int", st_int, v.iv);
    check("op_valid_cycle", valid_c, v.exp_valid_cyc);
    check("op_data", s_data, v.exp_data);
    check("op_rd", s_rd, v.rd);
    check("op_no_timeout", s_timeout, 0);
    for (int d = 0; d < v.dly; d++) begin
      cycle();
      check("bp_valid_held", s_valid, 1);
      check("bp_data_held", s_data, v.exp_data);
      check("bp_rd_held", s_rd, v.rd);
      check("bp_pipe_stall", s_pstall, 1);
    end
    in_ready = 1;
    cycle();
    check("hs_valid", s_valid, 1);
    check("hs_pipe_stall", s_pstall, 0);
    in_ready = 0;
    cycle();
    check("post_hs_ready", s_ready, 1);
    check("post_hs_valid", s_valid, 0);
  endtask

  typedef struct packed {
    logic [31:0] d;
    logic [4:0]  rd;
  } exp_t;

  exp_t q[$];
  bit   inflight  = 0;
  bit   start_due = 0;
  int   hs_count  = 0;

  // One randomized cycle scored against the transaction-level model.
  task automatic rnd_step();
    exp_t e;
    cycle();
    check("rnd_start_after_accept", s_start, start_due);
    if (!inflight) check("rnd_no_valid_when_idle", s_valid, 0);
    if (inflight) check("rnd_not_ready_in_flight", s_ready, 0);
    start_due = 0;
    if (inflight && s_valid && in_ready && !in_flush) begin
      e = q.pop_front();
      check("rnd_data", s_data, e.d);
      check("rnd_rd", s_rd, e.rd);
      inflight = 0;
      hs_count++;
    end else if (inflight && in_flush) begin
      void'(q.pop_front());
      inflight = 0;
    end
    if (s_ready && in_valid && !in_flush) begin
      q.push_back('{core_fn(in_fpu_op, in_rs1, in_rs2, in_int), in_rd});
      inflight  = 1;
      start_due = 1;
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL global_time_limit: bench still running, expected completion");
    $fatal(1);
  end

  initial begin
    int valid_c;
    bit saw_valid, saw_to;

    vecs[0] = '{FPU_OP_ADD, 32'h3F80_0000, 32'h4000_0000, 32'h0, 32'h4040_0000, 5'd7, 0, 0, 3, 32'h4040_0000};
    vecs[1] = '{FPU_OP_MUL, 32'h4040_0000, 32'h4080_0000, 32'h0, 32'h4140_0000, 5'd12, 5, 2, 8, 32'h4140_0000};
    vecs[2] = '{FPU_OP_SUB, 32'h0, 32'hFFFF_FFFF, 32'h0, 32'hFFFF_FFFF, 5'd31, 1, 0, 4, 32'hFFFF_FFFF};
    vecs[3] = '{FPU_OP_CVT_I2F, 32'h0, 32'h0, 32'd12345, 32'h4640_E400, 5'd3, 2, 1, 5, 32'h4640_E400};
    vecs[4] = '{FPU_OP_DIV, 32'h3F80_0000, 32'h0, 32'h0, 32'h7F80_0000, 5'd0, 0, 3, 3, 32'h7F80_0000};

    in_Rst = 1; in_valid = 0; in_flush = 0; in_ready = 0;
    in_fpu_stall = 0; in_fpu_data = '0;
    drive_op('0, '0, '0, '0, '0);
    cycle();
    cycle();
    check("rst_ready", s_ready, 1);
    check("rst_start", s_start, 0);
    check("rst_valid", s_valid, 0);
    check("rst_pipe_stall", s_pstall, 0);
    check("rst_data", s_data, 0);
    check("rst_rd", s_rd, 0);
    check("rst_timeout", s_timeout, 0);
    in_Rst = 0;

    for (int i = 0; i < 5; i++) run_op(vecs[i]);

    // Flush in WAIT while the core is still busy: drain, then idle.
    core_override = 0; core_lat = 6;
    drive_op(FPU_OP_MUL, 32'h1111_2222, 32'h3333_4444, 32'h5, 5'd9);
    in_valid = 1;
    cycle();
    check("fl_accept", s_ready, 1);
    in_valid = 0;
    for (int c = 1; c <= 9; c++) begin
      in_flush = (c == 3);
      cycle();
      check("fl_no_valid", s_valid, 0);
      check("fl_ready", s_ready, (c == 9));
    end
    in_flush = 0;
    run_op(vecs[0]);

    // Reset while waiting on the core.
    core_override = 0; core_lat = 4;
    drive_op(FPU_OP_SQRT, 32'hAAAA_5555, 32'h1234_5678, 32'h9, 5'd21);
    in_valid = 1;
    cycle();
    in_valid = 0;
    cycle();
    cycle();
    in_Rst = 1;
    cycle();
    in_Rst = 0;
    cycle();
    check("mrst_ready", s_ready, 1);
    check("mrst_start", s_start, 0);
    check("mrst_valid", s_valid, 0);
    check("mrst_pipe_stall", s_pstall, 0);
    check("mrst_data", s_data, 0);
    check("mrst_rd", s_rd, 0);
    check("mrst_op", s_op, 0);
    check("mrst_rs1", s_rs1, 0);
    check("mrst_rs2", s_rs2, 0);
    check("mrst_int", s_int, 0);
    run_op(vecs[1]);

    // Flush and ready together in DONE: flush wins.
    core_override = 1; override_val = 32'h1234_5678; core_lat = 0;
    drive_op(FPU_OP_ADD, 32'h1, 32'h2, 32'h3, 5'd5);
    in_valid = 1;
    cycle();
    in_valid = 0;
    cycle();
    cycle();
    cycle();
    check("fr_valid_in_done", s_valid, 1);
    in_flush = 1; in_ready = 1;
    cycle();
    check("fr_valid_that_cycle", s_valid, 1);
    check("fr_pipe_stall", s_pstall, 0);
    in_flush = 0; in_ready = 0;
    cycle();
    check("fr_valid_dropped", s_valid, 0);
    check("fr_idle", s_ready, 1);

    // Core stuck busy.
    core_stuck = 1; core_override = 1; override_val = 32'hDEAD_BEEF; core_lat = 0;
    drive_op(FPU_OP_DIV, 32'h7, 32'h8, 32'h9, 5'd17);
    in_valid = 1;
    cycle();
    in_valid = 0;
`ifdef FPU_TIMEOUT_EN
    valid_c = -1;
    for (int c = 1; c <= 30 && valid_c < 0; c++) begin
      cycle();
      if (s_valid) valid_c = c;
    end
    check("to_valid_cycle", valid_c, 10);
    check("to_nan", s_data, 32'h7FC0_0000);
    check("to_flag", s_timeout, 1);
    check("to_rd", s_rd, 17);
    cycle();
    check("to_flag_held", s_timeout, 1);
    core_stuck = 0;
    in_ready = 1;
    cycle();
    check("to_flag_hs", s_timeout, 1);
    in_ready = 0;
    cycle();
    check("to_flag_clear", s_timeout, 0);
    check("to_idle", s_ready, 1);
`else
    saw_valid = 0; saw_to = 0;
    for (int c = 1; c <= 100; c++) begin
      cycle();
      if (s_valid) saw_valid = 1;
      if (s_timeout) saw_to = 1;
    end
    check("stuck_no_valid", saw_valid, 0);
    check("stuck_no_timeout", saw_to, 0);
    check("stuck_pipe_stall", s_pstall, 1);
    core_stuck = 0;
    valid_c = -1;
    for (int c = 1; c <= 10 && valid_c < 0; c++) begin
      cycle();
      if (s_valid) valid_c = c;
    end
    check("stuck_recovers", valid_c > 0, 1);
    check("stuck_data", s_data, 32'hDEAD_BEEF);
    in_ready = 1;
    cycle();
    in_ready = 0;
    cycle();
    check("stuck_idle", s_ready, 1);
`endif

    // Randomized traffic against the scoreboard.
    core_override = 0; core_stuck = 0;
    inflight = 0; start_due = 0; q.delete();
    for (int n = 0; n < 1500; n++) begin
      in_valid  = 1'($urandom_range(0, 1));
      in_flush  = ($urandom_range(0, 24) == 0);
      in_ready  = ($urandom_range(0, 9) < 6);
      drive_op(5'($urandom_range(0, 8)), $urandom, $urandom, $urandom, 5'($urandom));
      core_lat  = $urandom_range(0, 4);
      rnd_step();
    end
    in_valid = 0; in_flush = 0; in_ready = 1;
    for (int n = 0; n < 40; n++) rnd_step();
    check("rnd_queue_empty", q.size(), 0);
    check("rnd_final_ready", s_ready, 1);
    check("rnd_enough_handshakes", hs_count > 50, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
